// File: rtl/sys_bus_pkg.sv
// Shared types and constants for the system-bus interconnect.
// Optional local timeout is enabled with the SYS_BUS_TIMEOUT_EN macro.
package sys_bus_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } sys_bus_state_e;

    localparam int SYS_BUS_SN = 8;
    localparam int SYS_BUS_AW = 32;
    localparam int SYS_BUS_DW = 32;
    localparam int SYS_BUS_RW = 20;
    localparam int SYS_BUS_TO = 24;

    // 1 MiB window index of each FPGA register block
    localparam logic [2:0] WIN_HK    = 3'd0;
    localparam logic [2:0] WIN_OSC   = 3'd1;
    localparam logic [2:0] WIN_ASG   = 3'd2;
    localparam logic [2:0] WIN_PID   = 3'd3;
    localparam logic [2:0] WIN_AMS   = 3'd4;
    localparam logic [2:0] WIN_DAISY = 3'd5;

    function automatic logic [7:0] win_onehot(input logic [2:0] idx);
        win_onehot = 8'b1 << idx;
    endfunction

endpackage

// File: rtl/sys_bus_timeout.sv
// Cycle counter for a pending slave access; flags expiry after TO busy cycles.
// Only instantiated when SYS_BUS_TIMEOUT_EN is defined.
module sys_bus_timeout #(
    parameter int TO = 24
) (
    input  logic sys_clk_i,
    input  logic sys_rst_i,
    input  logic i_clear,
    input  logic i_busy,
    output logic o_expired
);

    logic [7:0] r_cnt;

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_busy) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Counter holds j in the j-th busy cycle, so expiry lands TO cycles after the slave strobe
    assign o_expired = i_busy && (r_cnt == 8'(TO));

endmodule

// File: rtl/sys_bus_interconnect.sv
// Splits one system-bus master port into SN slave ports by 1 MiB address window.
// Define SYS_BUS_TIMEOUT_EN to answer a silent slave with an error after TO busy cycles.
module sys_bus_interconnect
    import sys_bus_pkg::*;
#(
    parameter int SN = SYS_BUS_SN,
    parameter int AW = SYS_BUS_AW,
    parameter int DW = SYS_BUS_DW,
    parameter int SW = DW / 8,
    parameter int RW = SYS_BUS_RW,
    parameter int TO = SYS_BUS_TO
) (
    input  logic               sys_clk_i,
    input  logic               sys_rst_i,
    input  logic [AW-1:0]      sys_addr_i,
    input  logic [DW-1:0]      sys_wdata_i,
    input  logic [SW-1:0]      sys_sel_i,
    input  logic               sys_wen_i,
    input  logic               sys_ren_i,
    output logic [DW-1:0]      sys_rdata_o,
    output logic               sys_err_o,
    output logic               sys_ack_o,
    output logic [AW-1:0]      sys_addr_o,
    output logic [DW-1:0]      sys_wdata_o,
    output logic [SW-1:0]      sys_sel_o,
    output logic [SN-1:0]      sys_wen_o,
    output logic [SN-1:0]      sys_ren_o,
    input  logic [SN*DW-1:0]   sys_rdata_i,
    input  logic [SN-1:0]      sys_err_i,
    input  logic [SN-1:0]      sys_ack_i,
    output sys_bus_state_e     dbg_state_o
);

    if (SN < 1 || SN > 8) begin : g_bad_sn
        $error("sys_bus_interconnect: SN must be 1..8");
    end
    if (TO < 1 || TO > 31) begin : g_bad_to
        $error("sys_bus_interconnect: TO must be 1..31");
    end

    sys_bus_state_e    r_state;
    sys_bus_state_e    w_state_nxt;

    logic [2:0]        r_idx;
    logic [AW-1:0]     r_addr;
    logic [DW-1:0]     r_wdata;
    logic [SW-1:0]     r_sel;
    logic [SN-1:0]     r_wen;
    logic [SN-1:0]     r_ren;
    logic              r_ack;
    logic              r_err;
    logic [DW-1:0]     r_rdata;

    logic [2:0]        w_idx_in;
    logic [7:0]        w_onehot;
    logic              w_strobe;
    logic              w_mapped;
    logic              w_latch;
    logic              w_ack_sel;
    logic              w_err_sel;
    logic [DW-1:0]     w_rdata_sel;
    logic              w_timeout;
    logic [SN-1:0]     w_wen_nxt;
    logic [SN-1:0]     w_ren_nxt;
    logic              w_ack_nxt;
    logic              w_err_nxt;
    logic [DW-1:0]     w_rdata_nxt;

    assign w_idx_in = sys_addr_i[RW+2:RW];
    assign w_onehot = win_onehot(w_idx_in);
    assign w_strobe = sys_wen_i | sys_ren_i;
    assign w_mapped = (32'(w_idx_in) < 32'(SN));

    // Only the slave latched at acceptance may complete a transaction
    always_comb begin
        w_ack_sel   = 1'b0;
        w_err_sel   = 1'b0;
        w_rdata_sel = '0;
        for (int i = 0; i < SN; i++) begin
            if (r_idx == 3'(i)) begin
                w_ack_sel   = sys_ack_i[i];
                w_err_sel   = sys_err_i[i];
                w_rdata_sel = sys_rdata_i[i*DW +: DW];
            end
        end
    end

`ifdef SYS_BUS_TIMEOUT_EN
    logic w_enter_busy;

    assign w_enter_busy = (r_state == IDLE) && (w_state_nxt == BUSY);

    sys_bus_timeout #(
        .TO (TO)
    ) u_timeout (
        .sys_clk_i (sys_clk_i),
        .sys_rst_i (sys_rst_i),
        .i_clear   (w_enter_busy),
        .i_busy    (r_state == BUSY),
        .o_expired (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_wen_nxt   = '0;
        w_ren_nxt   = '0;
        w_ack_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_rdata_nxt = '0;
        case (r_state)
            IDLE: begin
                if (w_strobe) begin
                    w_latch = 1'b1;
                    if (w_mapped) begin
                        // Write wins when both strobes arrive together
                        if (sys_wen_i) begin
                            w_wen_nxt = w_onehot[SN-1:0];
                        end else begin
                            w_ren_nxt = w_onehot[SN-1:0];
                        end
                        w_state_nxt = BUSY;
                    end else begin
                        w_ack_nxt = 1'b1;
                        w_err_nxt = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (w_ack_sel) begin
                    w_ack_nxt   = 1'b1;
                    w_err_nxt   = w_err_sel;
                    w_rdata_nxt = w_rdata_sel;
                    w_state_nxt = IDLE;
                end else if (w_timeout) begin
                    w_ack_nxt   = 1'b1;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_idx   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_sel   <= '0;
            r_wen   <= '0;
            r_ren   <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_wen   <= w_wen_nxt;
            r_ren   <= w_ren_nxt;
            r_ack   <= w_ack_nxt;
            r_err   <= w_err_nxt;
            r_rdata <= w_rdata_nxt;
            if (w_latch) begin
                r_idx   <= w_idx_in;
                r_addr  <= sys_addr_i;
                r_wdata <= sys_wdata_i;
                r_sel   <= sys_sel_i;
            end
        end
    end

    assign sys_addr_o  = r_addr;
    assign sys_wdata_o = r_wdata;
    assign sys_sel_o   = r_sel;
    assign sys_wen_o   = r_wen;
    assign sys_ren_o   = r_ren;
    assign sys_ack_o   = r_ack;
    assign sys_err_o   = r_err;
    assign sys_rdata_o = r_rdata;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_sys_bus_interconnect.sv
// Randomized scoreboard bench for sys_bus_interconnect built with six slaves,
// so windows 6 and 7 exercise the unmapped-error path.
module tb_sys_bus_interconnect;
    import sys_bus_pkg::*;

    localparam int SN = 6;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int RW = 20;
    localparam int TO = 24;
    localparam int AEW = 32 + 1 + DW + AW;
    localparam int SEW = 32 + SN + SN + AW + DW + SW;

    logic              clk;
    logic              rst;
    logic [AW-1:0]     sys_addr_i;
    logic [DW-1:0]     sys_wdata_i;
    logic [SW-1:0]     sys_sel_i;
    logic              sys_wen_i;
    logic              sys_ren_i;
    logic [DW-1:0]     sys_rdata_o;
    logic              sys_err_o;
    logic              sys_ack_o;
    logic [AW-1:0]     sys_addr_o;
    logic [DW-1:0]     sys_wdata_o;
    logic [SW-1:0]     sys_sel_o;
    logic [SN-1:0]     sys_wen_o;
    logic [SN-1:0]     sys_ren_o;
    logic [SN*DW-1:0]  s_rdata;
    logic [SN-1:0]     s_err;
    logic [SN-1:0]     s_ack;
    sys_bus_state_e    dbg_state;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int force_spur = -1;

    logic [AEW-1:0] exp_q[$];
    logic [SEW-1:0] exp_s_q[$];
    logic [AEW-1:0] mon_a;
    logic [SEW-1:0] mon_s;

    sys_bus_interconnect #(
        .SN(SN), .AW(AW), .DW(DW), .SW(SW), .RW(RW), .TO(TO)
    ) dut (
        .sys_clk_i   (clk),
        .sys_rst_i   (rst),
        .sys_addr_i  (sys_addr_i),
        .sys_wdata_i (sys_wdata_i),
        .sys_sel_i   (sys_sel_i),
        .sys_wen_i   (sys_wen_i),
        .sys_ren_i   (sys_ren_i),
        .sys_rdata_o (sys_rdata_o),
        .sys_err_o   (sys_err_o),
        .sys_ack_o   (sys_ack_o),
        .sys_addr_o  (sys_addr_o),
        .sys_wdata_o (sys_wdata_o),
        .sys_sel_o   (sys_sel_o),
        .sys_wen_o   (sys_wen_o),
        .sys_ren_o   (sys_ren_o),
        .sys_rdata_i (s_rdata),
        .sys_err_i   (s_err),
        .sys_ack_i   (s_ack),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance to the next cycle (just after the edge), drop master strobes and
    // refresh slave-side noise; slave quiet_idx never acks on its own.
    task automatic tick(input int quiet_idx);
        @(posedge clk);
        #1;
        sys_wen_i = 1'b0;
        sys_ren_i = 1'b0;
        for (int i = 0; i < SN; i++) begin
            s_rdata[i*DW +: DW] = $urandom;
            s_err[i] = 1'($urandom_range(0, 1));
            s_ack[i] = (i != quiet_idx) && ((i == force_spur) || ($urandom_range(0, 3) == 0));
        end
    endtask

    task automatic do_txn(input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic [SW-1:0] sl,
                          input logic we, input logic re, input int k,
                          input logic [DW-1:0] rd, input logic er, input int gap);
        int idx;
        int t;
        logic [SN-1:0] oh;
        idx = int'((a >> RW) & 32'h7);
        repeat (gap) tick(-1);
        tick(-1);
        t = cyc;
        sys_addr_i  = a;
        sys_wdata_i = wd;
        sys_sel_i   = sl;
        sys_wen_i   = we;
        sys_ren_i   = re;
        if (idx < SN) begin
            oh = '0;
            oh[idx] = 1'b1;
            exp_s_q.push_back({32'(t + 1), (we ? oh : SN'(0)), (we ? SN'(0) : oh), a, wd, sl});
            exp_q.push_back({32'(t + 2 + k), er, rd, a});
            tick(idx);
            for (int j = 0; j < k; j++) begin
                if ($urandom_range(0, 3) == 0) begin
                    sys_addr_i = $urandom;
                    sys_ren_i  = 1'b1;
                end
                tick(idx);
            end
            s_ack[idx] = 1'b1;
            s_err[idx] = er;
            s_rdata[idx*DW +: DW] = rd;
            tick(-1);
        end else begin
            exp_q.push_back({32'(t + 1), 1'b1, DW'(0), a});
            tick(-1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"},   64'(sys_ack_o),   64'(0));
        check({tag, "_err"},   64'(sys_err_o),   64'(0));
        check({tag, "_rdata"}, 64'(sys_rdata_o), 64'(0));
        check({tag, "_wen"},   64'(sys_wen_o),   64'(0));
        check({tag, "_ren"},   64'(sys_ren_o),   64'(0));
        check({tag, "_addr"},  64'(sys_addr_o),  64'(0));
        check({tag, "_wdata"}, 64'(sys_wdata_o), 64'(0));
        check({tag, "_sel"},   64'(sys_sel_o),   64'(0));
        check({tag, "_state"}, 64'(dbg_state),   64'(IDLE));
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (sys_ack_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 64'(1), 64'(0));
                end else begin
                    mon_a = exp_q.pop_front();
                    check("ack_cycle", 64'(cyc), 64'(mon_a[AEW-1 -: 32]));
                    check("ack_err",   64'(sys_err_o), 64'(mon_a[DW+AW]));
                    check("ack_rdata", 64'(sys_rdata_o), 64'(mon_a[AW +: DW]));
                    check("ack_addr",  64'(sys_addr_o), 64'(mon_a[AW-1:0]));
                end
            end else begin
                check("rdata_no_ack", 64'(sys_rdata_o), 64'(0));
                check("err_no_ack",   64'(sys_err_o),   64'(0));
            end
            if ((|sys_wen_o) || (|sys_ren_o)) begin
                if (exp_s_q.size() == 0) begin
                    check("unexpected_strobe", 64'({sys_wen_o, sys_ren_o}), 64'(0));
                end else begin
                    mon_s = exp_s_q.pop_front();
                    check("strobe_cycle", 64'(cyc), 64'(mon_s[SEW-1 -: 32]));
                    check("strobe_wen",   64'(sys_wen_o), 64'(mon_s[SW+DW+AW+SN +: SN]));
                    check("strobe_ren",   64'(sys_ren_o), 64'(mon_s[SW+DW+AW +: SN]));
                    check("strobe_addr",  64'(sys_addr_o), 64'(mon_s[SW+DW +: AW]));
                    check("strobe_wdata", 64'(sys_wdata_o), 64'(mon_s[SW +: DW]));
                    check("strobe_sel",   64'(sys_sel_o), 64'(mon_s[SW-1:0]));
                end
            end
        end
    end

    initial begin
        #2000000;
        total++;
        bad++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int t;
        int idx;
        int mode;
        logic [AW-1:0] a;
        rst = 1'b1;
        sys_addr_i = '0;
        sys_wdata_i = '0;
        sys_sel_i = '0;
        sys_wen_i = 1'b0;
        sys_ren_i = 1'b0;
        s_rdata = '0;
        s_err = '0;
        s_ack = '0;
        repeat (3) tick(-1);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // Directed cases
        do_txn(32'h4010_0004, 32'h1234_5678, 4'hF, 1'b1, 1'b0, 2, 32'h0BAD_0001, 1'b0, 1);
        do_txn(32'h4030_0000, 32'h0, 4'hF, 1'b0, 1'b1, 0, 32'hCAFE_F00D, 1'b0, 0);
        do_txn(32'h4070_0000, 32'h0, 4'hF, 1'b0, 1'b1, 0, 32'h0, 1'b0, 0);
        do_txn(32'h4060_0010, 32'h5555_AAAA, 4'h3, 1'b1, 1'b0, 0, 32'h0, 1'b0, 0);
        do_txn(32'h4020_0008, 32'hA5A5_5A5A, 4'hC, 1'b1, 1'b1, 1, 32'h1111_2222, 1'b1, 0);
        force_spur = 4;
        do_txn(32'h4000_0000, 32'h0, 4'hF, 1'b0, 1'b1, 5, 32'hDEAD_BEEF, 1'b0, 3);
        force_spur = -1;

        // Silent slave 2, with dropped strobes while it is pending
        tick(-1);
        t = cyc;
        a = 32'h4020_0010;
        sys_addr_i = a;
        sys_ren_i = 1'b1;
        exp_s_q.push_back({32'(t + 1), SN'(0), SN'(6'b000100), a, sys_wdata_i, sys_sel_i});
`ifdef SYS_BUS_TIMEOUT_EN
        exp_q.push_back({32'(t + 2 + TO), 1'b1, DW'(0), a});
`endif
        for (int j = 0; j < 100; j++) begin
            tick(2);
            if (j < 10 && $urandom_range(0, 2) == 0) begin
                sys_addr_i = $urandom;
                sys_wen_i = 1'b1;
            end
        end
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        s_ack[2] = 1'b1;
        s_err[2] = 1'b1;
        tick(2);
        do_txn(32'h4020_0014, 32'h0, 4'hF, 1'b0, 1'b1, 1, 32'h7777_8888, 1'b0, 1);

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            idx = $urandom_range(0, 7);
            mode = $urandom_range(0, 2);
            a = ($urandom & 32'hFF8F_FFFF) | (32'(idx) << RW);
            do_txn(a, $urandom, 4'($urandom), (mode != 1), (mode != 0),
                   $urandom_range(0, 6), $urandom, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 2));
        end

        repeat (4) tick(-1);
        check("ack_queue_drained", 64'(exp_q.size()), 64'(0));
        check("strobe_queue_drained", 64'(exp_s_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
